// File: rtl/vm_pkg.sv
// Shared definitions for the vending_machine_pro controller.
//   state_e : controller states
//   COIN_*  : face values of the accepted coins in CNY
// Configuration macro used by the design files: VM_CHANGE_EN.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_e;

    localparam int COIN_ONE  = 1;
    localparam int COIN_TWO  = 2;
    localparam int COIN_FIVE = 5;

endpackage

// File: rtl/vm_coin_decode.sv
// Combinational coin decoder.
//   i_one/i_two/i_five : coin pulses from the acceptor
//   coin_valid         : exactly one coin pulse is high
//   coin_illegal       : two or more coin pulses are high
//   value              : face value of the valid coin, 0 otherwise
module vm_coin_decode
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic                i_one,
    input  logic                i_two,
    input  logic                i_five,
    output logic                coin_valid,
    output logic                coin_illegal,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        coin_valid   = 1'b0;
        coin_illegal = 1'b0;
        value        = '0;
        case ({i_five, i_two, i_one})
            3'b000: ;
            3'b001: begin coin_valid = 1'b1; value = CREDIT_W'(COIN_ONE);  end
            3'b010: begin coin_valid = 1'b1; value = CREDIT_W'(COIN_TWO);  end
            3'b100: begin coin_valid = 1'b1; value = CREDIT_W'(COIN_FIVE); end
            default: coin_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vending_machine_pro.sv
// Coin-operated vending controller.
// Accumulates 1/2/5 CNY coins up to PRICE, strobes o_done, then returns any
// overpayment (or a cancelled credit) as one change word.
// Ports:
//   clk, rst (async, active low)
//   i_one_cny, i_two_cny, i_five_cny, i_cancel : single-cycle input pulses
//   o_done         : one-cycle dispense strobe
//   o_change_valid : one-cycle strobe qualifying o_change
//   o_change       : change/refund amount (0 when not valid)
//   o_credit       : current accumulated credit
//   o_reject       : coin not credited, acceptor must return it
// Configuration: VM_CHANGE_EN enables the CHANGE state, cancel and refunds.
// Without it, excess credit is discarded at VEND and cancel is ignored.
module vending_machine_pro
    import vm_pkg::*;
#(
    parameter int PRICE    = 5,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_one_cny,
    input  logic                i_two_cny,
    input  logic                i_five_cny,
    input  logic                i_cancel,
    output logic                o_done,
    output logic                o_change_valid,
    output logic [CREDIT_W-1:0] o_change,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_reject
);

    // Credit never exceeds PRICE + 4 (largest coin added to PRICE - 1).
    if (PRICE < 1 || (2 ** CREDIT_W) - 1 < PRICE + 4) begin : g_bad_cfg
        $fatal(1, "vending_machine_pro: CREDIT_W too small for PRICE");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic                coin_valid;
    logic                coin_illegal;
    logic [CREDIT_W-1:0] coin_value;

    vm_coin_decode #(.CREDIT_W(CREDIT_W)) u_dec (
        .i_one        (i_one_cny),
        .i_two        (i_two_cny),
        .i_five       (i_five_cny),
        .coin_valid   (coin_valid),
        .coin_illegal (coin_illegal),
        .value        (coin_value)
    );

    state_e              state_q,  state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                done_q,   done_d;
    logic                reject_q, reject_d;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = coin_illegal;
        case (state_q)
            IDLE, COLLECT: begin
`ifdef VM_CHANGE_EN
                if (i_cancel && state_q == COLLECT) begin
                    // Cancel beats a simultaneous coin; that coin goes back.
                    state_d  = CHANGE;
                    reject_d = coin_valid | coin_illegal;
                end else
`endif
                if (coin_valid) begin
                    credit_d = credit_q + coin_value;
                    state_d  = (credit_d >= PRICE_C) ? VEND : COLLECT;
                end
            end
            VEND: begin
                reject_d = coin_valid | coin_illegal;
`ifdef VM_CHANGE_EN
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_d != '0) ? CHANGE : IDLE;
`else
                credit_d = '0;
                state_d  = IDLE;
`endif
            end
`ifdef VM_CHANGE_EN
            CHANGE: begin
                reject_d = coin_valid | coin_illegal;
                credit_d = '0;
                state_d  = IDLE;
            end
`endif
            default: begin
                credit_d = '0;
                state_d  = IDLE;
            end
        endcase
        // Strobes are registered alongside the state they belong to, so they
        // are high exactly while the machine sits in VEND / CHANGE.
        done_d = (state_d == VEND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            done_q   <= done_d;
            reject_q <= reject_d;
        end
    end

`ifdef VM_CHANGE_EN
    logic                chg_vld_q, chg_vld_d;
    logic [CREDIT_W-1:0] chg_q,     chg_d;

    always_comb begin
        chg_vld_d = (state_d == CHANGE);
        chg_d     = chg_vld_d ? credit_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg_vld_q <= 1'b0;
            chg_q     <= '0;
        end else begin
            chg_vld_q <= chg_vld_d;
            chg_q     <= chg_d;
        end
    end

    assign o_change_valid = chg_vld_q;
    assign o_change       = chg_q;
`else
    // Cancel has no function without the refund path.
    logic unused_cancel;
    assign unused_cancel  = i_cancel;
    assign o_change_valid = 1'b0;
    assign o_change       = '0;
`endif

    assign o_done   = done_q;
    assign o_credit = credit_q;
    assign o_reject = reject_q;

endmodule

// File: doc/vending_machine_pro.md
# vending_machine_pro

Parametrised successor of the coin-operated vending controller. It accepts 1/2/5 CNY coin pulses and accumulates credit up to a configurable price. It pulses a dispense strobe, then returns overpayment or a cancelled credit as a single change word. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers, all on one clock domain.

## Interface
- PRICE, default 5: item price in CNY; legal range 1..(2**CREDIT_W − 5).
- CREDIT_W, default 4: credit/change width; must satisfy 2**CREDIT_W − 1 ≥ PRICE + 4 (elaboration-time check, fatal on violation).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_one_cny  in  1  single-cycle pulse, 1 CNY coin accepted by the acceptor.
- i_two_cny  in  1  single-cycle pulse, 2 CNY coin.
- i_five_cny  in  1  single-cycle pulse, 5 CNY coin.
- i_cancel  in  1  single-cycle pulse, refund request.
- o_done  out  1  one-cycle dispense strobe.
- o_change_valid  out  1  one-cycle strobe, o_change is valid.
- o_change  out  CREDIT_W  change/refund amount in CNY.
- o_credit  out  CREDIT_W  current accumulated credit.
- o_reject  out  1  one-cycle strobe, coin not credited and must be returned by the acceptor.

## Operation
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND, CHANGE.
- Legal coin: exactly one coin input high. Value is 1, 2 or 5.
- Illegal coin: two or more coin inputs high in one cycle. All are rejected, o_reject pulses, credit is unchanged.
- IDLE/COLLECT, legal coin:
  - credit ← credit + value.
  - If the new credit ≥ PRICE, go to VEND.
  - Otherwise go to COLLECT.
- VEND:
  - o_done = 1 for exactly one cycle.
  - credit ← credit − PRICE.
  - Next state is CHANGE if the remainder is > 0, else IDLE.
- CHANGE:
  - o_change_valid = 1 and o_change = credit for one cycle.
  - credit ← 0, then go to IDLE.
- i_cancel in COLLECT: go to CHANGE with the full credit and no o_done. i_cancel in IDLE, VEND or CHANGE is ignored.
- Cancel together with a coin in the same cycle: cancel wins and the coin is rejected (o_reject).
- Any coin arriving in VEND or CHANGE is rejected (o_reject) and never credited.
- No overflow is possible: credit < PRICE before every add, so the maximum is PRICE + 4, guaranteed by the CREDIT_W check.

## Timing
- Reset values: state IDLE, credit 0, o_done 0, o_change_valid 0, o_change 0, o_credit 0, o_reject 0.
- All outputs are registered.
- Coin pulse at edge n:
  - o_credit is updated after edge n.
  - If the price is reached, o_done is high in cycle n+1.
  - o_change_valid is high in cycle n+2, if any change is due.
- Cancel at edge n: o_change_valid is high in cycle n+1.
- o_reject is high in the cycle after the offending input.
- o_change holds 0 whenever o_change_valid is 0.
- Reset asserted mid-transaction: everything clears immediately. Credit is lost and no change is issued.
- Back-to-back purchases: the next coin is accepted on the first cycle back in IDLE.

## Configuration
- VM_CHANGE_EN defined: change and refund behave as described above.
- VM_CHANGE_EN undefined:
  - CHANGE state is not built.
  - VEND clears credit to 0 and returns to IDLE, so excess is discarded.
  - i_cancel is ignored.
  - o_change_valid and o_change are tied to 0.

## Structure
- Package vm_pkg holds:
  - state enum {IDLE, COLLECT, VEND, CHANGE};
  - coin value constants COIN_ONE=1, COIN_TWO=2, COIN_FIVE=5.
- Sub-module vm_coin_decode is combinational. It takes the three coin pulses and outputs coin_valid, coin_illegal and a value of width CREDIT_W.

## Test plan
All scenarios use PRICE=5 and CREDIT_W=4.
- Coins 1, 2, 2 in separate cycles: o_credit goes 1 → 3 → 5; o_done pulses once; no o_change_valid; returns to IDLE with credit 0.
- Coins 2, 2, 5: credit reaches 9; o_done, then next cycle o_change_valid with o_change=4; credit 0.
- Coins 1, 2, then i_cancel: o_change_valid with o_change=3; o_done never asserts.
- i_one_cny and i_two_cny in the same cycle: o_reject pulses and credit stays 0. i_cancel together with i_five_cny in COLLECT (credit 2): refund of 2, o_reject.
- Coin 5 followed by i_two_cny during VEND: o_reject, change 0, state IDLE.
- Coins 1, 2, then rst low: all outputs 0 asynchronously.
- VM_CHANGE_EN undefined, coins 2, 5: o_done pulses, o_change_valid stays 0, credit 0, i_cancel has no effect.
